// File: rtl/deserializador_4b_pkg.sv
// Shared encodings for the serial link: word width, receiver FSM states and bit-order codes.
// Pure declarations; no logic, no latency, no flow control.
// Used by both the transmitter (registrodesp) and this receiver.
package deserializador_4b_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic DIR_MSB = 1'b1;
    localparam logic DIR_LSB = 1'b0;

endpackage

// File: rtl/deserializador_4b_nucleo_desp.sv
// Dir-controlled shift register with clear and parallel load; sh_nxt previews the post-shift value.
// Latency: one edge per shift; sh_nxt is combinational from s_in/dir.
// No backpressure: shifts whenever shift=1. Priority is clr, then load, then shift.
module deserializador_4b_nucleo_desp
    import deserializador_4b_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             shift,
    input  logic             dir,
    input  logic             s_in,
    output logic [WIDTH-1:0] sh,
    output logic [WIDTH-1:0] sh_nxt
);

    always_comb begin
        if (dir == DIR_MSB) begin
            sh_nxt = {sh[WIDTH-2:0], s_in};
        end else begin
            sh_nxt = {s_in, sh[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh <= '0;
        end else if (clr) begin
            sh <= '0;
        end else if (load) begin
            sh <= load_dat;
        end else if (shift) begin
            sh <= sh_nxt;
        end
    end

endmodule

// File: rtl/deserializador_4b.sv
// Serial-to-parallel receiver: collects WIDTH enb-qualified bits in dir order, presents word on q.
// Latency: q/valid update on the same edge that samples the final bit.
// Backpressure: one-word holding register; a word completing while valid=1 and ready=0 is dropped and sets sticky overrun.
module deserializador_4b
    import deserializador_4b_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             dir,
    input  logic             s_in,
    input  logic             clr,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             overrun,
    output logic             busy
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              dir_lat;
    logic              dir_eff;
    logic              word_done;
    logic [WIDTH-1:0]  sh;
    logic [WIDTH-1:0]  sh_nxt;

    // The first bit of a word uses the live dir input; later bits use the latched value.
    assign dir_eff   = (state == IDLE) ? dir : dir_lat;
    assign word_done = enb && !clr && (state == RECV) && (cnt == CNT_W'(WIDTH-1));

    deserializador_4b_nucleo_desp #(
        .WIDTH (WIDTH)
    ) u_nucleo (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr || word_done),
        .load     (1'b0),
        .load_dat ('0),
        .shift    (enb),
        .dir      (dir_eff),
        .s_in     (s_in),
        .sh       (sh),
        .sh_nxt   (sh_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (enb) begin
            case (state)
                IDLE:    state_nxt = RECV;
                RECV:    state_nxt = word_done ? IDLE : RECV;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == RECV);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            dir_lat <= DIR_MSB;
        end else if (clr) begin
            cnt <= '0;
        end else if (enb) begin
            cnt <= word_done ? '0 : cnt + 1'b1;
            if (state == IDLE) begin
                dir_lat <= dir;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (clr) begin
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else if (word_done) begin
            if (!valid || ready) begin
                q     <= sh_nxt;
                valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule
